// File: rtl/spi_cmd_target.sv
// SPI mode-0 target: oversamples the SPI pins in the clk domain, deserialises
// 72-bit {rw, addr[6:0], data[63:0]} frames and turns them into register-bus
// commands. Writes go out on a valid/ready port. Reads sample the register
// file's combinational read data and shift it back out on MISO.
module spi_cmd_target #(
  parameter int SCLK_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_rw,
  output logic [6:0]  cmd_addr,
  output logic [63:0] cmd_wdata,
  input  logic [63:0] cmd_rdata,
  output logic        cmd_drop,
  output logic        frame_abort
);

  localparam int S = SCLK_SYNC_STAGES;

  typedef enum logic [2:0] {IDLE, HEADER, RDLOAD, DATA, DONE} state_t;

  state_t        state;
  logic [S-1:0]  sclk_sy, cs_sy, mosi_sy;
  logic          sclk_d, cs_d;
  logic [6:0]    bit_cnt;
  logic [70:0]   rx_sr;
  logic [63:0]   tx_sr;
  logic          rd_kill;

  logic sclk_s, cs_s, mosi_s;
  logic rise, fall, cs_fall, cs_rise;
  logic [71:0] frame;

  assign sclk_s  = sclk_sy[S-1];
  assign cs_s    = cs_sy[S-1];
  assign mosi_s  = mosi_sy[S-1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign cs_fall = ~cs_s & cs_d;
  assign cs_rise = cs_s & ~cs_d;
  // Frame as it stands once the bit arriving this cycle is shifted in.
  assign frame   = {rx_sr, mosi_s};

  // Pin synchronisers plus one extra flop on sclk/cs_n for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sy <= '0;
      cs_sy   <= '1;
      mosi_sy <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b1;
    end else begin
      sclk_sy[0] <= spi_sclk;
      cs_sy[0]   <= spi_cs_n;
      mosi_sy[0] <= spi_mosi;
      for (int i = 1; i < S; i++) begin
        sclk_sy[i] <= sclk_sy[i-1];
        cs_sy[i]   <= cs_sy[i-1];
        mosi_sy[i] <= mosi_sy[i-1];
      end
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  // Frame FSM: bit counting, command issue/hold, read shift-out, pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      rd_kill     <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_rw      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      cmd_drop    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      cmd_drop    <= 1'b0;
      frame_abort <= 1'b0;
      spi_miso_oe <= ~cs_s;
      // A new command is only loaded while cmd_valid is low, so this clear
      // never races a load below.
      if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;

      case (state)
        IDLE: begin
          spi_miso <= 1'b0;
          if (cs_fall) begin
            state   <= HEADER;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rd_kill <= 1'b0;
          end
        end

        HEADER, RDLOAD, DATA: begin
          if (cs_rise) begin
            frame_abort <= 1'b1;
            spi_miso    <= 1'b0;
            state       <= IDLE;
          end else if (state == RDLOAD) begin
            // A read dropped behind a pending write shifts out zeros.
            tx_sr <= rd_kill ? '0 : cmd_rdata;
            state <= DATA;
          end else if (rise) begin
            rx_sr   <= frame[70:0];
            bit_cnt <= bit_cnt + 7'd1;
            if (state == HEADER && bit_cnt == 7'd7) begin
              if (frame[7]) begin
                state <= RDLOAD;
                if (cmd_valid) begin
                  cmd_drop <= 1'b1;
                  rd_kill  <= 1'b1;
                end else begin
                  cmd_addr <= frame[6:0];
                  cmd_rw   <= 1'b1;
                end
              end else begin
                state <= DATA;
              end
            end else if (state == DATA && bit_cnt == 7'd71) begin
              state    <= DONE;
              spi_miso <= 1'b0;
              if (!frame[71]) begin
                if (cmd_valid) begin
                  cmd_drop <= 1'b1;
                end else begin
                  cmd_valid <= 1'b1;
                  cmd_rw    <= 1'b0;
                  cmd_addr  <= frame[70:64];
                  cmd_wdata <= frame[63:0];
                end
              end
            end
          end else if (fall && state == DATA) begin
            spi_miso <= tx_sr[63];
            tx_sr    <= {tx_sr[62:0], 1'b0};
          end
        end

        DONE: begin
          spi_miso <= 1'b0;
          if (cs_rise) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_target.sv
// Directed bench for spi_cmd_target: a vector table of full frames plus
// hand-written sequences for back-pressure, abort, over-length and reset.
module tb_spi_cmd_target;

  localparam int HALF = 8;  // clk cycles per SCLK phase

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        cmd_ready = 1'b1;
  logic        spi_miso, spi_miso_oe, cmd_valid, cmd_rw, cmd_drop, frame_abort;
  logic [6:0]  cmd_addr;
  logic [63:0] cmd_wdata, cmd_rdata;

  int tests = 0;
  int fails = 0;

  // Register-file read model.
  function automatic logic [63:0] rdata_model(input logic [6:0] a);
    if (a == 7'h7F) return 64'h0000_0000_0000_6702;
    return {1'b0, a, 56'h0} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  assign cmd_rdata = rdata_model(cmd_addr);

  spi_cmd_target #(.SCLK_SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_rdata(cmd_rdata),
    .cmd_drop(cmd_drop), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  // Monitor: accepted commands, pulse counts, pulse width, payload stability.
  int          acc_cnt = 0, drop_cnt = 0, abort_cnt = 0, vcyc = 0;
  int          pulse_err = 0, stab_err = 0;
  logic [6:0]  acc_addr = '0;
  logic [63:0] acc_data = '0;
  logic        acc_rw = 1'b0;
  logic        p_valid = 1'b0, p_ready = 1'b0, p_drop = 1'b0, p_abort = 1'b0;
  logic [6:0]  p_addr = '0;
  logic [63:0] p_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        acc_cnt  <= acc_cnt + 1;
        acc_addr <= cmd_addr;
        acc_data <= cmd_wdata;
        acc_rw   <= cmd_rw;
      end
      if (cmd_valid) vcyc <= vcyc + 1;
      if (cmd_drop) drop_cnt <= drop_cnt + 1;
      if (frame_abort) abort_cnt <= abort_cnt + 1;
      if ((cmd_drop && p_drop) || (frame_abort && p_abort) || (cmd_drop && frame_abort))
        pulse_err <= pulse_err + 1;
      if (p_valid && !p_ready && (!cmd_valid || cmd_addr != p_addr || cmd_wdata != p_data))
        stab_err <= stab_err + 1;
      p_valid <= cmd_valid; p_ready <= cmd_ready;
      p_addr  <= cmd_addr;  p_data  <= cmd_wdata;
      p_drop  <= cmd_drop;  p_abort <= frame_abort;
    end else begin
      p_valid <= 1'b0; p_drop <= 1'b0; p_abort <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mkf(input logic rw, input logic [6:0] a, input logic [63:0] d);
    return {rw, a, d};
  endfunction

  // Host side of one frame; bits are MSB-first from bits[nbits-1].
  // rx captures MISO at each host rising edge, aligned the same way.
  task automatic send_frame(input logic [79:0] bits, input int nbits, output logic [79:0] rx);
    rx = '0;
    @(negedge clk) cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[nbits-1-i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      rx[nbits-1-i] = spi_miso;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (2*HALF) @(negedge clk);
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [63:0] data;
    logic [63:0] exp_miso;
    int          exp_acc;
  } vec_t;

  vec_t        tbl[4];
  logic [79:0] rx;
  int          a0, d0, b0, v0;

  initial begin
    tbl[0] = '{1'b0, 7'h0A, 64'h0000_0000_DEAD_BEEF, 64'h0, 1};
    tbl[1] = '{1'b1, 7'h7F, 64'h0, 64'h0000_0000_0000_6702, 0};
    tbl[2] = '{1'b0, 7'h33, 64'h0123_4567_89AB_CDEF, 64'h0, 1};
    tbl[3] = '{1'b1, 7'h05, 64'h0, 64'h0423_4567_89AB_CDEF, 0};

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_rw", cmd_rw, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_wdata", cmd_wdata, 0);
    chk("rst_miso", {spi_miso, spi_miso_oe}, 0);
    chk("rst_pulses", {cmd_drop, frame_abort}, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Table-driven full frames with cmd_ready held high
    foreach (tbl[k]) begin
      a0 = acc_cnt; d0 = drop_cnt; b0 = abort_cnt; v0 = vcyc;
      send_frame({8'h0, mkf(tbl[k].rw, tbl[k].addr, tbl[k].data)}, 72, rx);
      chk($sformatf("v%0d_accepts", k), acc_cnt - a0, tbl[k].exp_acc);
      chk($sformatf("v%0d_valid_cycles", k), vcyc - v0, tbl[k].exp_acc);
      chk($sformatf("v%0d_pulses", k), {drop_cnt - d0, abort_cnt - b0}, 0);
      chk($sformatf("v%0d_hdr_miso", k), rx[71:64], 0);
      if (tbl[k].rw) begin
        chk($sformatf("v%0d_miso_data", k), rx[63:0], tbl[k].exp_miso);
      end else begin
        chk($sformatf("v%0d_addr", k), acc_addr, tbl[k].addr);
        chk($sformatf("v%0d_wdata", k), acc_data, tbl[k].data);
        chk($sformatf("v%0d_rw", k), acc_rw, 0);
      end
    end

    // Back-pressure: held write, dropped write, dropped read, then accept
    cmd_ready = 1'b0;
    a0 = acc_cnt; d0 = drop_cnt;
    send_frame({8'h0, mkf(1'b0, 7'h08, 64'h1111_2222_3333_4444)}, 72, rx);
    repeat (200) @(negedge clk);
    chk("bp_valid_held", cmd_valid, 1);
    chk("bp_addr", cmd_addr, 7'h08);
    chk("bp_wdata", cmd_wdata, 64'h1111_2222_3333_4444);
    send_frame({8'h0, mkf(1'b0, 7'h09, 64'h5555)}, 72, rx);
    chk("bp_wr_drop", drop_cnt - d0, 1);
    chk("bp_addr_kept", cmd_addr, 7'h08);
    send_frame({8'h0, mkf(1'b1, 7'h7F, 64'h0)}, 72, rx);
    chk("bp_rd_drop", drop_cnt - d0, 2);
    chk("bp_rd_miso_zero", rx[63:0], 0);
    chk("bp_addr_after_rd", {cmd_rw, cmd_addr}, {1'b0, 7'h08});
    @(negedge clk) cmd_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("bp_one_accept", acc_cnt - a0, 1);
    chk("bp_accept_addr", acc_addr, 7'h08);
    chk("bp_valid_low", cmd_valid, 0);

    // Abort after 40 bits, then a normal frame
    a0 = acc_cnt; b0 = abort_cnt; v0 = vcyc;
    send_frame({40'h0, mkf(1'b0, 7'h12, 64'hAAAA_BBBB_CCCC_DDDD) >> 32}, 40, rx);
    chk("abort_pulse", abort_cnt - b0, 1);
    chk("abort_no_cmd", vcyc - v0, 0);
    send_frame({8'h0, mkf(1'b0, 7'h13, 64'h77)}, 72, rx);
    chk("post_abort_accept", acc_cnt - a0, 1);
    chk("post_abort_addr", {acc_addr, acc_data}, {7'h13, 64'h77});

    // Over-length 80-bit frame
    a0 = acc_cnt; b0 = abort_cnt; d0 = drop_cnt;
    send_frame({mkf(1'b0, 7'h11, 64'hFEDC_BA98_7654_3210), 8'hFF}, 80, rx);
    chk("ovl_accept", acc_cnt - a0, 1);
    chk("ovl_payload", {acc_addr, acc_data}, {7'h11, 64'hFEDC_BA98_7654_3210});
    chk("ovl_miso_tail", rx[7:0], 0);
    chk("ovl_no_pulses", {abort_cnt - b0, drop_cnt - d0}, 0);

    // Reset mid-frame during DATA of a write
    a0 = acc_cnt;
    fork
      send_frame({8'h0, mkf(1'b0, 7'h22, 64'h9999)}, 72, rx);
      begin
        repeat (40*2*HALF) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_ctl", {cmd_valid, cmd_rw, cmd_addr, spi_miso, spi_miso_oe, cmd_drop, frame_abort}, 0);
        chk("mrst_wdata", cmd_wdata, 0);
        @(negedge clk) rst_n = 1'b1;
      end
    join
    chk("mrst_no_cmd", acc_cnt - a0, 0);
    send_frame({8'h0, mkf(1'b0, 7'h04, 64'h0F)}, 72, rx);
    chk("mrst_next_accept", acc_cnt - a0, 1);
    chk("mrst_next_payload", {acc_addr, acc_data}, {7'h04, 64'h0F});

    chk("pulse_width", pulse_err, 0);
    chk("payload_stable", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_cmd_target.md
# spi_cmd_target

SPI target front end that converts host SPI frames into register-bus commands for the GPU register file, and returns register read data on MISO. It oversamples the SPI pins in the `clk` domain, deserialises 72-bit frames, and presents writes through a valid/ready command port. Reads drive the register file's combinational read path directly. It sits between the external SPI pins and the command FIFO / register file.

## Interface
- `SCLK_SYNC_STAGES`, default 2: synchroniser depth on `spi_sclk`, `spi_cs_n` and `spi_mosi`.
- `clk` input 1: system clock; the only clock in the block.
- `rst_n` input 1: reset, synchronous and active-low.
- `spi_sclk` input 1: SPI clock, mode 0 (CPOL=0, CPHA=0); asynchronous to `clk`.
- `spi_cs_n` input 1: SPI chip select, active-low.
- `spi_mosi` input 1: host-to-GPU data, MSB first.
- `spi_miso` output 1: GPU-to-host data.
- `spi_miso_oe` output 1: MISO output enable; equals synchronised `!spi_cs_n`.
- `cmd_valid` output 1: write command pending.
- `cmd_ready` input 1: downstream accepts the command this cycle.
- `cmd_rw` output 1: 1 = read, 0 = write.
- `cmd_addr` output 7: register address.
- `cmd_wdata` output 64: write data.
- `cmd_rdata` input 64: combinational read data for `cmd_addr`.
- `cmd_drop` output 1: one-cycle pulse when a frame is discarded.
- `frame_abort` output 1: one-cycle pulse when CS deasserts mid-frame.

## Operation
- Frame layout, MSB first, 72 bits:
  - bit 71 = rw
  - bits 70:64 = addr
  - bits 63:0 = data
- Input handling:
  - All three SPI inputs pass through `SCLK_SYNC_STAGES` flops.
  - A further flop on sclk/cs_n provides edge detection.
  - MOSI is sampled on the detected sclk rising edge. MISO updates on the detected falling edge.
- Bit counter is 7 bits. It is cleared on detected cs_n falling edge and increments on each detected sclk rising edge while CS is active.
- FSM states:
  - IDLE: CS inactive. On cs_n falling → HEADER.
  - HEADER: counts bits 0–7. After the 8th rising edge:
    - read frame → RDLOAD
    - write frame → DATA
  - RDLOAD: one cycle; see read path below. Then → DATA.
  - DATA: bits 8–71. After the 72nd rising edge:
    - write frame → issue write
    - either frame type → DONE
  - DONE: further sclk edges are ignored. MISO is driven 0. Stay until cs_n rises → IDLE.
- CS rises in HEADER, RDLOAD or DATA:
  - pulse `frame_abort`
  - no command is issued
  - → IDLE
- Read path:
  - At the 8th rising edge, `cmd_addr` takes the received addr and `cmd_rw`=1.
  - In RDLOAD, the 64-bit shift-out register loads `cmd_rdata`.
  - On each subsequent falling edge, `spi_miso` = next bit, starting with bit 63.
  - Reads never assert `cmd_valid`.
- Write path:
  - On completion, `cmd_rw`=0, `cmd_addr`/`cmd_wdata` take the frame fields, and `cmd_valid`=1.
  - `cmd_valid` and all payload fields are held stable until the cycle where `cmd_valid && cmd_ready`. `cmd_valid` drops the next cycle.
- Write pending when a new write frame completes: the new frame is discarded, `cmd_drop` pulses, and the pending command is unchanged.
- Write pending when a read header completes: the read is discarded, `cmd_drop` pulses, and MISO shifts all zeros for that frame. `cmd_addr` is not disturbed.
- MISO is 0 during HEADER, in IDLE and in DONE.

## Timing
- Reset values:
  - all outputs 0: `cmd_valid`, `cmd_rw`, `cmd_addr`, `cmd_wdata`, `spi_miso`, `spi_miso_oe`, `cmd_drop`, `frame_abort`
  - FSM = IDLE, bit counter = 0, synchroniser flops = 1 for cs_n and 0 otherwise
- `rst_n` low mid-frame:
  - everything returns to reset values
  - a pending write is lost
  - the FSM re-enters via the next cs_n falling edge
- Pin-to-edge-detect latency is `SCLK_SYNC_STAGES`+1 clk.
- Required: SCLK high and low phases ≥ `SCLK_SYNC_STAGES`+3 clk each; CS setup and hold to the first/last sclk edge ≥ the same.
- Read latency:
  - `cmd_addr` valid 1 clk after the 8th detected rising edge.
  - Shift register loaded the following clk.
  - First data bit on MISO at the first detected falling edge after that. This must precede the 9th rising edge, which is guaranteed by the SCLK constraint.
- Write issue: `cmd_valid` rises 1 clk after the 72nd detected rising edge.
- `cmd_drop` and `frame_abort` are exactly one clk wide. They are never asserted together.

## Test plan
- **Write:** rw=0, addr=0x0A, data=0x0000_0000_DEAD_BEEF, `cmd_ready`=1 → single-cycle `cmd_valid` with `cmd_addr`=0x0A, `cmd_wdata`=0x...DEADBEEF, `cmd_rw`=0; no pulses.
- **Read:** rw=1, addr=0x7F, bench model returns 0x0000_0000_0000_6702 → MISO bits 8–71 of the frame equal 0x0000_0000_0000_6702; `cmd_valid` never high.
- **Back-pressure:**
  - Write addr=0x08 with `cmd_ready`=0 for 200 clk → `cmd_valid` held, payload stable.
  - Second write addr=0x09 completes meanwhile → `cmd_drop` pulse.
  - Raise `cmd_ready` → exactly one accepted command, addr 0x08.
- **Abort:** cs_n rises after 40 bits → one `frame_abort` pulse, no `cmd_valid`, next full frame processed normally.
- **Over-length frame:** 80-bit write frame → exactly one command from the first 72 bits; MISO 0 during bits 72–79.
- **Reset mid-frame:** `rst_n` low for 3 clk during DATA of a write → all outputs 0, no command; following write to addr 0x04 data 0x0F → `cmd_wdata`=0x0F.
